dm_responder: RTL and testbench
===============================

DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: data memory size in 32-bit words (power of two); AW = log2(DEPTH_WORDS).
REQ-002 SHALL have parameter LATENCY, default 1: wait-state cycles between request acceptance and response, 0..7.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  CPU memory request present.
REQ-006 SHALL have port req_ready  output  1  responder accepts the request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_be  input  4  byte-lane enables, bit i selects bits 8i+7:8i.
REQ-010 SHALL have port req_wdata  input  32  store data, already lane-aligned.
REQ-011 SHALL have port req_pc  input  32  PC of the issuing instruction, used for store trace only.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-013 SHALL have port rsp_rdata  output  32  full word read (loads); 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  request rejected (address/alignment), qualified by rsp_valid.

Function
REQ-015 SHALL implement FSM states CLEAR, IDLE, WAIT, RESP.
- CLEAR: write 0 to word clr_idx, clr_idx++; after word DEPTH_WORDS-1 go to IDLE.
- IDLE: req_ready=1. On req_valid, latch request; go to WAIT if LATENCY>0, else RESP.
- WAIT: count LATENCY cycles, then go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then go to IDLE.
REQ-016 SHALL assert req_ready only in IDLE; the request is accepted on req_valid && req_ready.
REQ-017 SHALL place rsp_valid exactly LATENCY+1 cycles after the acceptance edge; it SHALL have no backpressure.
REQ-018 SHALL index memory by word address req_addr[AW+1:2] and ignore req_addr[1:0] except for the alignment check.
REQ-019 SHALL flag an error when any of req_addr[31:AW+2] is nonzero.
REQ-020 SHALL also flag an error when req_be is not in {0001,0010,0100,1000,0011,1100,1111}.
REQ-021 SHALL also flag an error when req_be's lowest set lane differs from req_addr[1:0].
REQ-022 SHALL, for an erroring request, perform no write, return rsp_err=1 and rsp_rdata=0.
REQ-023 SHALL commit a store in the cycle the FSM enters RESP, updating only enabled lanes and preserving the others.
REQ-024 SHALL, for a load, return the whole word read when the FSM enters RESP; byte/half extraction is the CPU's job.
REQ-025 SHALL make a load issued right after a store to the same word return the updated data.
REQ-026 SHALL hold rsp_rdata and rsp_err at 0 whenever rsp_valid=0.

Reset
REQ-027 SHALL, while reset=0, force: state=CLEAR, clr_idx=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
REQ-028 SHALL, on reset asserted mid-transaction, abandon it with no write and no response; the memory is re-cleared from word 0.
REQ-029 SHALL not reset the memory array asynchronously; zeroing is done only by the CLEAR sweep.

Configuration
REQ-030 SHALL, with macro DM_DISPLAY_EN defined, print on every committed store: "%d@%h: *%h <= %h" with $time, latched pc, {addr[31:2],2'b00} and the merged word.
REQ-031 SHALL, without DM_DISPLAY_EN, emit no display; req_pc stays a port but is unused, and the logic is otherwise identical.

Structure
REQ-032 SHALL take FSM state encoding, valid-BE constants and the error-check helper from shared package mips_pkg.
REQ-033 SHALL contain one sub-module, dm_ram: single-port, synchronous-write, byte-enable word RAM sized DEPTH_WORDS.

Verification
REQ-034 SHALL test: reset released -> req_ready=0 for 1024 cycles, then 1; a load of 0x0000_0010 returns 0x0000_0000.
REQ-035 SHALL test: sw 0x1234_5678 @0x8, be=1111 -> rsp_valid 2 cycles after acceptance (LATENCY=1); a load @0x8 then returns 0x1234_5678.
REQ-036 SHALL test: sb wdata 0x0000_AB00 @0x9, be=0010 over 0x1234_5678 -> a load @0x8 returns 0x1234_AB78.
REQ-037 SHALL test: sh @0x9 be=0011, and a load @0x1000 (DEPTH 1024) -> rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-038 SHALL test: reset pulsed while in WAIT for a store @0x4 -> no rsp_valid, and a load @0x4 after CLEAR returns 0.
REQ-039 SHALL test: LATENCY=0 with back-to-back req_valid -> one accept every 2 cycles and rsp_valid in the cycle after each accept.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types, byte-enable constants and request-check helpers for the data-memory responder.
package mips_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned LANES = 4;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } dm_state_e;

  localparam logic [LANES-1:0] BE_B0   = 4'b0001;
  localparam logic [LANES-1:0] BE_B1   = 4'b0010;
  localparam logic [LANES-1:0] BE_B2   = 4'b0100;
  localparam logic [LANES-1:0] BE_B3   = 4'b1000;
  localparam logic [LANES-1:0] BE_H0   = 4'b0011;
  localparam logic [LANES-1:0] BE_H1   = 4'b1100;
  localparam logic [LANES-1:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic             we;
    logic [XLEN-1:0]  addr;
    logic [LANES-1:0] be;
    logic [XLEN-1:0]  wdata;
  } dm_req_t;

  function automatic logic be_legal(input logic [LANES-1:0] be);
    logic ok;
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_WORD: ok = 1'b1;
      default:                                          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [1:0] be_low_lane(input logic [LANES-1:0] be);
    logic [1:0] lane;
    lane = 2'd0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (be[i]) lane = 2'(i);
    end
    return lane;
  endfunction

  function automatic logic [XLEN-1:0] be_mask(input logic [LANES-1:0] be);
    logic [XLEN-1:0] mask;
    for (int i = 0; i < LANES; i++) mask[8*i +: 8] = {8{be[i]}};
    return mask;
  endfunction

  // Out-of-range address, illegal lane pattern, or lanes not starting at the byte offset.
  function automatic logic dm_req_err(input logic [XLEN-1:0] addr,
                                      input logic [LANES-1:0] be,
                                      input int unsigned aw);
    logic range_err;
    range_err = (addr >> (aw + 32'd2)) != 32'd0;
    return range_err || !be_legal(be) || (be_low_lane(be) != addr[1:0]);
  endfunction

endpackage

// File: rtl/dm_ram.sv
// Single-port word RAM: synchronous byte-enable write, combinational read of the addressed word.
module dm_ram
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [LANES-1:0] be_i,
  input  logic [XLEN-1:0]  wdata_i,
  output logic [XLEN-1:0]  rdata_c_o
);

  // Contents are deliberately not reset; the owner zeroes them with a sweep.
  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < LANES; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_c_o = mem_q[addr_i];

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: clears RAM after reset, then serves one load/store at a time with fixed latency.
// Define DM_DISPLAY_EN to print a trace line for every committed store.
module dm_responder
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [LANES-1:0] req_be,
  input  logic [XLEN-1:0]  req_wdata,
  input  logic [XLEN-1:0]  req_pc,
  output logic             rsp_valid,
  output logic [XLEN-1:0]  rsp_rdata,
  output logic             rsp_err
);

  localparam int unsigned      AW        = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0]    CLR_LAST  = AW'(DEPTH_WORDS - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(LATENCY - 1);

  dm_state_e        state_q, state_d;
  logic [AW-1:0]    clr_idx_q, clr_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dm_req_t          req_q, req_d;
  logic             ready_q, ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  logic             enter_resp;
  logic             req_err;
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [LANES-1:0] ram_be;
  logic [XLEN-1:0]  ram_wdata;
  logic [XLEN-1:0]  ram_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_CLEAR;
      clr_idx_q   <= '0;
      cnt_q       <= '0;
      req_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state logic; acceptance in IDLE needs only req_valid since ready mirrors IDLE.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == CLR_LAST) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (req_valid) begin
          req_d.we    = req_we;
          req_d.addr  = req_addr;
          req_d.be    = req_be;
          req_d.wdata = req_wdata;
          cnt_d       = '0;
          state_d     = (LATENCY == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) state_d = ST_RESP;
        else                    cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_CLEAR;
    endcase
  end

  // req_d carries the live request when LATENCY=0 jumps straight from IDLE to RESP.
  assign enter_resp = (state_d == ST_RESP);
  assign req_err    = dm_req_err(req_d.addr, req_d.be, AW);
  assign ram_we     = (state_q == ST_CLEAR) || (enter_resp && req_d.we && !req_err);
  assign ram_addr   = (state_q == ST_CLEAR) ? clr_idx_q : req_d.addr[AW+1:2];
  assign ram_be     = (state_q == ST_CLEAR) ? BE_WORD : req_d.be;
  assign ram_wdata  = (state_q == ST_CLEAR) ? '0 : req_d.wdata;

  always_comb begin
    ready_d     = (state_d == ST_IDLE);
    rsp_valid_d = enter_resp;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    if (enter_resp) begin
      rsp_err_d = req_err;
      if (!req_err && !req_d.we) rsp_rdata_d = ram_rdata;
    end
  end

  dm_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk       (clk),
    .we_i      (ram_we),
    .addr_i    (ram_addr),
    .be_i      (ram_be),
    .wdata_i   (ram_wdata),
    .rdata_c_o (ram_rdata)
  );

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef DM_DISPLAY_EN
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] merged;

  assign pc_d   = (state_q == ST_IDLE && req_valid) ? req_pc : pc_q;
  assign merged = (ram_rdata & ~be_mask(req_d.be)) | (req_d.wdata & be_mask(req_d.be));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  always_ff @(posedge clk) begin
    if (reset && enter_resp && req_d.we && !req_err)
      $display("%d@%h: *%h <= %h", $time, pc_d, {req_d.addr[31:2], 2'b00}, merged);
  end
`else
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: LATENCY=1/DEPTH=1024 and LATENCY=0/DEPTH=256 instances.
module tb_dm_responder;

  localparam int unsigned D0 = 1024;
  localparam int unsigned D1 = 256;
  localparam int unsigned L0 = 1;
  localparam int unsigned L1 = 0;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic [1:0]       req_valid, req_ready, req_we, rsp_valid, rsp_err;
  logic [1:0][31:0] req_addr, req_wdata, req_pc, rsp_rdata;
  logic [1:0][3:0]  req_be;

  int     errors = 0;
  int     checks = 0;
  longint cyc    = 0;
  int     rsp_cnt [2];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    longint      due;
  } exp_t;

  exp_t        sbq0 [$];
  exp_t        sbq1 [$];
  logic [31:0] model [2][1024];
  int unsigned depth [2] = '{D0, D1};
  int unsigned lat   [2] = '{L0, L1};
  logic [3:0]  legal [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

  dm_responder #(.DEPTH_WORDS(D0), .LATENCY(L0)) u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_be(req_be[0]), .req_wdata(req_wdata[0]),
    .req_pc(req_pc[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dm_responder #(.DEPTH_WORDS(D1), .LATENCY(L1)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_be(req_be[1]), .req_wdata(req_wdata[1]),
    .req_pc(req_pc[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? sbq0.size() : sbq1.size();
  endfunction

  function automatic void push(input int d, input exp_t e);
    if (d == 0) sbq0.push_back(e);
    else        sbq1.push_back(e);
  endfunction

  function automatic void pop(input int d, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '{rdata: 32'h0, err: 1'b0, due: 0};
    if (d == 0 && sbq0.size() > 0) begin e = sbq0.pop_front(); ok = 1'b1; end
    if (d == 1 && sbq1.size() > 0) begin e = sbq1.pop_front(); ok = 1'b1; end
  endfunction

  // Reference behaviour: plain word-array memory with rules applied directly to the request.
  function automatic void model_req(input int d, input logic we, input logic [31:0] addr,
                                    input logic [3:0] be, input logic [31:0] wdata,
                                    output logic [31:0] rdata, output logic err);
    int          lowest;
    bit          be_ok;
    int unsigned word;
    lowest = -1;
    be_ok  = 1'b0;
    for (int k = 0; k < 7; k++) if (be == legal[k]) be_ok = 1'b1;
    for (int i = 0; i < 4; i++) if (be[i] && lowest < 0) lowest = i;
    err   = (longint'(addr) >= longint'(depth[d]) * 4) || !be_ok || (lowest != int'(addr[1:0]));
    rdata = 32'h0;
    if (!err) begin
      word = addr / 4;
      if (we) begin
        for (int i = 0; i < 4; i++) if (be[i]) model[d][word][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        rdata = model[d][word];
      end
    end
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    bit   got;
    for (int d = 0; d < 2; d++) begin
      if (rsp_valid[d] === 1'b1) begin
        rsp_cnt[d]++;
        pop(d, e, got);
        if (!got) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp_d%0d: got rsp_valid=1 with rdata %h, required no response", d, rsp_rdata[d]);
        end else begin
          check($sformatf("rdata_d%0d", d), rsp_rdata[d], e.rdata);
          check($sformatf("err_d%0d", d), 32'(rsp_err[d]), 32'(e.err));
          check($sformatf("rsp_cycle_d%0d", d), 32'(cyc), 32'(e.due));
        end
      end else begin
        check($sformatf("idle_rdata_d%0d", d), rsp_rdata[d], 32'h0);
        check($sformatf("idle_err_d%0d", d), 32'(rsp_err[d]), 32'h0);
      end
    end
  end

  task automatic issue(input int d, input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input bit keep, output longint acc);
    exp_t        e;
    logic [31:0] r;
    logic        er;
    int          n;
    n   = 0;
    acc = -1;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_be[d]    = be;
    req_wdata[d] = wdata;
    req_pc[d]    = $urandom;
    while (req_ready[d] !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (req_ready[d] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout_d%0d: req_ready=%b, required 1 within 3000 cycles", d, req_ready[d]);
      req_valid[d] = 1'b0;
    end else begin
      model_req(d, we, addr, be, wdata, r, er);
      e.rdata = r;
      e.err   = er;
      e.due   = cyc + 1 + longint'(lat[d]);
      push(d, e);
      acc = cyc;
      @(posedge clk);
      #1;
      if (!keep) req_valid[d] = 1'b0;
    end
  endtask

  task automatic wait_drain(input int d);
    int n;
    n = 0;
    while (qsize(d) > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (qsize(d) > 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout_d%0d: %0d responses outstanding, required 0", d, qsize(d));
      if (d == 0) sbq0.delete();
      else        sbq1.delete();
    end
    @(negedge clk);
  endtask

  // Hold reset, check the reset outputs, release, and time the clear sweep on both instances.
  task automatic reset_and_clear();
    longint rel, t0, t1;
    int     n;
    reset     = 1'b0;
    req_valid = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_ready_d%0d", d), 32'(req_ready[d]), 32'h0);
      check($sformatf("rst_rsp_valid_d%0d", d), 32'(rsp_valid[d]), 32'h0);
      for (int i = 0; i < 1024; i++) model[d][i] = 32'h0;
    end
    reset = 1'b1;
    rel   = cyc;
    t0    = -1;
    t1    = -1;
    n     = 0;
    while ((t0 < 0 || t1 < 0) && n < 2000) begin
      @(negedge clk);
      n++;
      if (req_ready[0] === 1'b1 && t0 < 0) t0 = cyc - rel;
      if (req_ready[1] === 1'b1 && t1 < 0) t1 = cyc - rel;
    end
    check("clear_cycles_d0", 32'(t0), 32'(D0));
    check("clear_cycles_d1", 32'(t1), 32'(D1));
  endtask

  task automatic rand_req(input int d, output logic we, output logic [31:0] addr, output logic [3:0] be);
    logic [1:0] low;
    we = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 9) < 8) be = legal[$urandom_range(0, 6)];
    else                          be = 4'($urandom);
    low = 2'd0;
    for (int i = 3; i >= 0; i--) if (be[i]) low = 2'(i);
    if ($urandom_range(0, 9) >= 8) low = 2'($urandom);
    addr = {26'($urandom_range(0, 15)), 4'h0} >> 2;
    addr = (addr << 2) | 32'(low);
    case ($urandom_range(0, 19))
      0:       addr = addr | (32'h1 << $urandom_range(12, 31));
      1:       addr = 32'(depth[d] * 4) | 32'(low);
      default: ;
    endcase
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    longint      a;
    longint      accs [6];
    int          cnt_before;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    int          d;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_be    = '0;
    req_wdata = '0;
    req_pc    = '0;
    rsp_cnt   = '{0, 0};

    reset_and_clear();
    issue(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, a);

    issue(0, 1'b1, 32'h8, 4'hF, 32'h1234_5678, 1'b0, a);
    issue(0, 1'b0, 32'h8, 4'hF, 32'h0, 1'b0, a);
    issue(0, 1'b1, 32'h9, 4'b0010, 32'h0000_AB00, 1'b0, a);
    issue(0, 1'b0, 32'h8, 4'hF, 32'h0, 1'b0, a);

    issue(0, 1'b1, 32'h9, 4'b0011, 32'hFFFF_FFFF, 1'b0, a);
    issue(0, 1'b0, 32'h1000, 4'hF, 32'h0, 1'b0, a);
    issue(0, 1'b0, 32'h8, 4'hF, 32'h0, 1'b0, a);
    wait_drain(0);

    issue(0, 1'b1, 32'h4, 4'hF, 32'hDEAD_BEEF, 1'b0, a);
    issue(0, 1'b0, 32'h4, 4'hF, 32'h0, 1'b0, a);
    wait_drain(0);
    check("ready_before_abort", 32'(req_ready[0]), 32'h1);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h4;
    req_be[0]    = 4'hF;
    req_wdata[0] = 32'hCAFE_F00D;
    @(negedge clk);
    check("abort_in_wait", 32'(req_ready[0]), 32'h0);
    cnt_before = rsp_cnt[0];
    reset_and_clear();
    check("abort_no_rsp", 32'(rsp_cnt[0] - cnt_before), 32'h0);
    issue(0, 1'b0, 32'h4, 4'hF, 32'h0, 1'b0, a);
    wait_drain(0);

    for (int k = 0; k < 6; k++) begin
      issue(1, 1'((k % 2) == 0), 32'(32'h20 + (k / 2) * 4), 4'hF, $urandom, 1'b1, accs[k]);
    end
    req_valid[1] = 1'b0;
    wait_drain(1);
    for (int k = 1; k < 6; k++) check($sformatf("b2b_spacing_%0d", k), 32'(accs[k] - accs[k-1]), 32'h2);

    for (int k = 0; k < 300; k++) begin
      d = $urandom_range(0, 1);
      rand_req(d, we, addr, be);
      issue(d, we, addr, be, $urandom, 1'b0, a);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain(0);
    wait_drain(1);
    check("final_queue_d0", 32'(sbq0.size()), 32'h0);
    check("final_queue_d1", 32'(sbq1.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
